// File: rtl/uart_wb_pkg.sv
// Shared constants for the UART-to-Wishbone bridge: register offsets, STATUS
// bit positions, CTRL bit positions and the TX engine state encoding.
package uart_wb_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int ST_RX_COUNT_LSB = 0;
    localparam int ST_TX_FREE_LSB  = 8;
    localparam int ST_RX_EMPTY     = 16;
    localparam int ST_TX_FULL      = 17;
    localparam int ST_RX_OVERRUN   = 18;
    localparam int ST_TX_DROP      = 19;
    localparam int ST_RX_UNDERRUN  = 20;

    localparam int CTRL_RX_IRQ_EN  = 0;
    localparam int CTRL_TX_IRQ_EN  = 1;
    localparam int CTRL_OVR_IRQ_EN = 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_WAIT  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter; a push and a pop in the
// same cycle both take effect, even when full.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] head_q, head_d;
    logic [DEPTH_LOG2-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[head_q];

    // A full FIFO still accepts a push when the same cycle frees a slot.
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        head_d  = head_q + DEPTH_LOG2'(do_pop);
        tail_d  = tail_q + DEPTH_LOG2'(do_push);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[tail_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_wb_bridge.sv
// Wishbone slave exposing a UART character stream through RX/TX FIFOs, with
// sticky error flags, an interrupt enable register and a TX handshake engine.
module uart_wb_bridge
    import uart_wb_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8,
    parameter int BLOCKING   = 1
) (
    input  logic              clk_bus,
    input  logic              rst_bus,
    input  logic [31:0]       dat_i,
    output logic [31:0]       dat_o,
    input  logic [31:0]       adr_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [3:0]        sel_i,
    output logic              ack_o,
    output logic              err_o,
    output logic              rty_o,
    output logic              stall_o,
    input  logic              uart_ready,
    input  logic [DATA_W-1:0] uart_dat_i,
    input  logic              uart_busy,
    output logic              uart_start,
    output logic [DATA_W-1:0] uart_dat_o,
    output logic              irq_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic [1:0]        reg_sel;
    logic              req, is_data, accept;
    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic              rx_pop, rx_full, rx_empty;
    logic [DATA_W-1:0] tx_pop_data, rx_pop_data;
    logic [CNT_W-1:0]  tx_count, rx_count, tx_free;
    logic [31:0]       status_word;
    logic              w1c;

    logic [31:0]       dat_q, dat_d;
    logic              ack_q, ack_d, err_q, err_d, irq_q, irq_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic              ovr_q, ovr_d, drop_q, drop_d, und_q, und_d;
    tx_state_e         tx_state_q, tx_state_d;
    logic [DATA_W-1:0] tx_dat_q, tx_dat_d;

    logic              unused_bits;
    assign unused_bits = ^{sel_i, adr_i[31:4], adr_i[1:0], dat_i};

    assign reg_sel = adr_i[3:2];
    assign req     = cyc_i & stb_i;
    assign is_data = (reg_sel == REG_DATA);
    assign stall_o = (BLOCKING != 0) && req && is_data && (we_i ? tx_full : rx_empty);
    assign accept  = req & ~stall_o;
    assign tx_push = accept & we_i & is_data;
    assign rx_pop  = accept & ~we_i & is_data;
    assign w1c     = accept & we_i & (reg_sel == REG_STATUS);
    assign tx_free = CNT_W'(DEPTH) - tx_count;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk       (clk_bus),
        .rst       (rst_bus),
        .push      (tx_push),
        .push_data (dat_i[DATA_W-1:0]),
        .pop       (tx_pop),
        .pop_data  (tx_pop_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk       (clk_bus),
        .rst       (rst_bus),
        .push      (uart_ready),
        .push_data (uart_dat_i),
        .pop       (rx_pop),
        .pop_data  (rx_pop_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    always_comb begin
        status_word = '0;
        status_word[ST_RX_COUNT_LSB +: 8] = 8'(rx_count);
        status_word[ST_TX_FREE_LSB +: 8]  = 8'(tx_free);
        status_word[ST_RX_EMPTY]          = rx_empty;
        status_word[ST_TX_FULL]           = tx_full;
        status_word[ST_RX_OVERRUN]        = ovr_q;
        status_word[ST_TX_DROP]           = drop_q;
        status_word[ST_RX_UNDERRUN]       = und_q;
    end

    // Bus response path: registered one cycle after accept; set events win over W1C.
    always_comb begin
        ack_d  = accept & (reg_sel != REG_RSVD);
        err_d  = accept & (reg_sel == REG_RSVD);
        dat_d  = '0;
        ctrl_d = ctrl_q;
        if (accept && !we_i) begin
            case (reg_sel)
                REG_DATA:   dat_d = rx_empty ? '0 : {{(32-DATA_W){1'b0}}, rx_pop_data};
                REG_STATUS: dat_d = status_word;
                REG_CTRL:   dat_d = {29'd0, ctrl_q};
                default:    dat_d = '0;
            endcase
        end
        if (accept && we_i && reg_sel == REG_CTRL) begin
            ctrl_d = dat_i[2:0];
        end
        ovr_d  = (ovr_q  & ~(w1c & dat_i[ST_RX_OVERRUN]))  | (uart_ready & rx_full & ~rx_pop);
        drop_d = (drop_q & ~(w1c & dat_i[ST_TX_DROP]))     | (tx_push & tx_full & ~tx_pop);
        und_d  = (und_q  & ~(w1c & dat_i[ST_RX_UNDERRUN])) | (rx_pop & rx_empty);
        irq_d  = (ctrl_q[CTRL_RX_IRQ_EN] & ~rx_empty)
               | (ctrl_q[CTRL_TX_IRQ_EN] & tx_empty)
               | (ctrl_q[CTRL_OVR_IRQ_EN] & (ovr_q | drop_q));
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_dat_d   = tx_dat_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty && !uart_busy) begin
                    tx_pop     = 1'b1;
                    tx_dat_d   = tx_pop_data;
                    tx_state_d = TX_START;
                end
            end
            TX_START: if (uart_busy)  tx_state_d = TX_WAIT;
            TX_WAIT:  if (!uart_busy) tx_state_d = TX_IDLE;
            default:  tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_bus) begin
        if (rst_bus) begin
            dat_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            irq_q      <= 1'b0;
            ctrl_q     <= '0;
            ovr_q      <= 1'b0;
            drop_q     <= 1'b0;
            und_q      <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_dat_q   <= '0;
        end else begin
            dat_q      <= dat_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            irq_q      <= irq_d;
            ctrl_q     <= ctrl_d;
            ovr_q      <= ovr_d;
            drop_q     <= drop_d;
            und_q      <= und_d;
            tx_state_q <= tx_state_d;
            tx_dat_q   <= tx_dat_d;
        end
    end

    assign dat_o      = dat_q;
    assign ack_o      = ack_q;
    assign err_o      = err_q;
    assign rty_o      = 1'b0;
    assign irq_o      = irq_q;
    assign uart_start = (tx_state_q == TX_START);
    assign uart_dat_o = tx_dat_q;

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Directed bench for uart_wb_bridge: a stalling (BLOCKING=1) and a non-stalling
// (BLOCKING=0) instance share stimulus; 'target' selects which one is driven.
module tb_uart_wb_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we, ready, target;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic [7:0]  rdat;
    logic        busy_b, busy_n;

    logic        cyc_b, stb_b, rdy_b, cyc_n, stb_n, rdy_n;
    logic [31:0] dato_b, dato_n;
    logic        ack_b, err_b, rty_b, stall_b, start_b, irq_b;
    logic        ack_n, err_n, rty_n, stall_n, start_n, irq_n;
    logic [7:0]  udat_b, udat_n;

    logic [31:0] dat_t;
    logic        ack_t, err_t, stall_t, start_t, irq_t;
    logic [7:0]  udat_t;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign cyc_b = cyc & ~target;
    assign stb_b = stb & ~target;
    assign rdy_b = ready & ~target;
    assign cyc_n = cyc & target;
    assign stb_n = stb & target;
    assign rdy_n = ready & target;

    assign dat_t   = target ? dato_n  : dato_b;
    assign ack_t   = target ? ack_n   : ack_b;
    assign err_t   = target ? err_n   : err_b;
    assign stall_t = target ? stall_n : stall_b;
    assign start_t = target ? start_n : start_b;
    assign irq_t   = target ? irq_n   : irq_b;
    assign udat_t  = target ? udat_n  : udat_b;

    uart_wb_bridge #(.DEPTH_LOG2(4), .DATA_W(8), .BLOCKING(1)) dut (
        .clk_bus(clk), .rst_bus(rst), .dat_i(dat), .dat_o(dato_b), .adr_i(adr),
        .cyc_i(cyc_b), .stb_i(stb_b), .we_i(we), .sel_i(sel),
        .ack_o(ack_b), .err_o(err_b), .rty_o(rty_b), .stall_o(stall_b),
        .uart_ready(rdy_b), .uart_dat_i(rdat), .uart_busy(busy_b),
        .uart_start(start_b), .uart_dat_o(udat_b), .irq_o(irq_b)
    );

    uart_wb_bridge #(.DEPTH_LOG2(4), .DATA_W(8), .BLOCKING(0)) dut_nb (
        .clk_bus(clk), .rst_bus(rst), .dat_i(dat), .dat_o(dato_n), .adr_i(adr),
        .cyc_i(cyc_n), .stb_i(stb_n), .we_i(we), .sel_i(sel),
        .ack_o(ack_n), .err_o(err_n), .rty_o(rty_n), .stall_o(stall_n),
        .uart_ready(rdy_n), .uart_dat_i(rdat), .uart_busy(busy_n),
        .uart_start(start_n), .uart_dat_o(udat_n), .irq_o(irq_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                       output logic [31:0] rd, output logic ak, output logic er);
        int waited = 0;
        @(negedge clk);
        adr = a; we = w; dat = d; cyc = 1'b1; stb = 1'b1;
        #1;
        while (stall_t === 1'b1 && waited < 300) begin
            @(negedge clk); #1; waited++;
        end
        if (waited >= 300) begin
            checks++; errors++;
            $error("FAIL stall_timeout: observed=%0d cycles expected=<300", waited);
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rd = dat_t; ak = ack_t; er = err_t;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input string tag);
        logic [31:0] rd; logic ak, er;
        bus(a, 1'b1, d, rd, ak, er);
        chk({tag, "_ack"}, ak, 1);
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] rd; logic ak, er;
        bus(a, 1'b0, 32'd0, rd, ak, er);
        chk({tag, "_ack"}, ak, 1);
        chk(tag, rd, exp);
    endtask

    task automatic pulse(input logic [7:0] c);
        @(negedge clk);
        rdat = c; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic set_busy(input logic v);
        if (target) busy_n = v;
        else        busy_b = v;
    endtask

    // Wait for a transmit request, check the character, then complete the busy handshake.
    task automatic tx_handshake(input logic [7:0] exp, input string tag);
        int n = 0;
        while (start_t !== 1'b1 && n < 100) begin
            @(negedge clk); n++;
        end
        chk({tag, "_start"}, start_t, 1);
        chk({tag, "_dat"}, udat_t, exp);
        @(negedge clk);
        chk({tag, "_hold"}, start_t, 1);
        set_busy(1'b1);
        @(negedge clk);
        chk({tag, "_drop"}, start_t, 0);
        chk({tag, "_stable"}, udat_t, exp);
        set_busy(1'b0);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        ak, er;
        int          cnt;

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0;
        sel = 4'hF; ready = 1'b0; rdat = '0; busy_b = 1'b0; busy_n = 1'b0; target = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack_b, 0);
        chk("rst_err", err_b, 0);
        chk("rst_start", start_b, 0);
        chk("rst_udat", udat_b, 0);
        chk("rst_dato", dato_b, 0);
        chk("rst_irq", irq_b, 0);
        chk("rst_rty", rty_b, 0);
        chk("rst_nb_start", start_n, 0);
        chk("rst_nb_dato", dato_n, 0);
        rst = 1'b0;

        rd_chk(32'h4, 32'h0001_1000, "status_rst");
        wr(32'h8, 32'hFFFF_FFFF, "ctrl_wr");
        rd_chk(32'h8, 32'h7, "ctrl_rd");
        chk("irq_tx_empty", irq_b, 1);
        wr(32'h8, 32'h0, "ctrl_clr");
        @(negedge clk);
        chk("irq_off", irq_b, 0);

        bus(32'hC, 1'b1, 32'h3, rd, ak, er);
        chk("rsvd_wr_err", er, 1);
        chk("rsvd_wr_ack", ak, 0);
        bus(32'hC, 1'b0, 32'h0, rd, ak, er);
        chk("rsvd_rd_err", er, 1);
        chk("rsvd_rd_ack", ak, 0);
        rd_chk(32'h8, 32'h0, "ctrl_after_rsvd");

        // Two characters out of the TX FIFO with the busy handshake.
        wr(32'h0, 32'h41, "tx41");
        wr(32'h0, 32'h42, "tx42");
        tx_handshake(8'h41, "tx_a");
        tx_handshake(8'h42, "tx_b");
        rd_chk(32'h4, 32'h0001_1000, "status_tx_done");

        // Stalled read on empty RX, released by an arriving character.
        @(negedge clk);
        adr = 32'h0; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        #1 chk("stall_empty", stall_b, 1);
        @(negedge clk);
        chk("stall_no_ack", ack_b, 0);
        rdat = 8'h5A; ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        @(negedge clk);
        chk("stall_released", stall_b, 0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("stall_ack", ack_b, 1);
        chk("stall_dat", dato_b, 32'h5A);

        // RX overrun, W1C, then simultaneous push and pop while full.
        for (int i = 0; i < 17; i++) pulse(8'(8'h10 + i));
        rd_chk(32'h4, 32'h0004_1010, "status_overrun");
        wr(32'h4, 32'h0004_0000, "w1c_ovr");
        rd_chk(32'h4, 32'h0000_1010, "status_ovr_clr");
        @(negedge clk);
        adr = 32'h0; we = 1'b0; cyc = 1'b1; stb = 1'b1; rdat = 8'h77; ready = 1'b1;
        #1 chk("full_pushpop_stall", stall_b, 0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; ready = 1'b0;
        @(negedge clk);
        chk("full_pushpop_ack", ack_b, 1);
        chk("full_pushpop_dat", dato_b, 32'h10);
        rd_chk(32'h4, 32'h0000_1010, "status_full_pushpop");
        for (int i = 1; i < 16; i++) rd_chk(32'h0, 32'h10 + i, "rx_order");
        rd_chk(32'h0, 32'h77, "rx_last");
        rd_chk(32'h4, 32'h0001_1000, "status_rx_drained");

        // Non-stalling instance: TX drop while busy, then exactly 16 transmitted.
        target = 1'b1;
        busy_n = 1'b1;
        for (int i = 0; i < 17; i++) wr(32'h0, 32'h30 + i, "nb_tx");
        rd_chk(32'h4, 32'h000B_0000, "nb_status_full");
        busy_n = 1'b0;
        for (int i = 0; i < 16; i++) tx_handshake(8'(8'h30 + i), "nb_tx_seq");
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (start_n) cnt++;
        end
        chk("nb_no_extra_tx", cnt, 0);
        rd_chk(32'h4, 32'h0009_1000, "nb_status_drop");
        rd_chk(32'h0, 32'h0, "nb_underrun_dat");
        rd_chk(32'h4, 32'h0019_1000, "nb_status_underrun");
        wr(32'h4, 32'h0018_0000, "nb_w1c");
        rd_chk(32'h4, 32'h0001_1000, "nb_status_clr");

        // W1C coinciding with a fresh overrun leaves the flag set.
        for (int i = 0; i < 16; i++) pulse(8'(8'h50 + i));
        @(negedge clk);
        adr = 32'h4; we = 1'b1; dat = 32'h0004_0000; cyc = 1'b1; stb = 1'b1;
        rdat = 8'hEE; ready = 1'b1;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; ready = 1'b0;
        @(negedge clk);
        chk("nb_w1c_race_ack", ack_n, 1);
        rd_chk(32'h4, 32'h0004_1010, "nb_w1c_race_status");

        // Reset while a character is being offered to the transmitter.
        target = 1'b0;
        wr(32'h8, 32'h1, "ctrl_rx_irq");
        pulse(8'h61);
        pulse(8'h62);
        wr(32'h0, 32'h99, "tx99");
        cnt = 0;
        while (start_b !== 1'b1 && cnt < 100) begin
            @(negedge clk); cnt++;
        end
        chk("pre_rst_start", start_b, 1);
        chk("pre_rst_irq", irq_b, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_start", start_b, 0);
        chk("mid_rst_udat", udat_b, 0);
        chk("mid_rst_irq", irq_b, 0);
        chk("mid_rst_ack", ack_b, 0);
        rst = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (start_b || ack_b || err_b) cnt++;
        end
        chk("post_rst_quiet", cnt, 0);
        rd_chk(32'h4, 32'h0001_1000, "post_rst_status");
        rd_chk(32'h8, 32'h0, "post_rst_ctrl");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
